// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage with in-order prefetch queue
//
// Purpose:
//   Owns the fetch PC and issues in-order requests to a variable-latency
//   instruction memory. Returned words land in a DEPTH-entry prefetch queue
//   that the core drains through a valid/ready handshake. A redirect flushes
//   the queue and restarts fetch at the (word-aligned) target.
//
// Ports:
//   clk, rst          core clock; asynchronous active-low reset
//   imem_req_valid    fetch request valid (slot available)
//   imem_req_ready    memory accepts the request this cycle
//   imem_req_addr     word-aligned fetch address (current fetch PC)
//   imem_rsp_valid    response word valid, strictly in request order
//   imem_rsp_data     returned instruction word
//   redirect_valid    taken branch/jump: flush and refetch
//   redirect_pc       redirect target, bits [1:0] ignored
//   instr_valid       head entry holds a returned instruction
//   instr_ready       core consumes the head entry this cycle
//   instr, instr_pc   head instruction word and its address

module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int          PW      = $clog2(DEPTH);
  localparam int          CW      = PW + 1;
  localparam logic [CW:0] DEPTH_A = DEPTH[CW:0];

  // Queue storage
  logic [31:0]      slot_pc   [DEPTH];
  logic [31:0]      slot_data [DEPTH];
  logic [DEPTH-1:0] slot_filled;

  // head: oldest entry, tail: next slot to allocate, fill: oldest unfilled
  logic [PW-1:0] head, tail, fill;
  logic [CW-1:0] count;        // allocated slots (buffered + in-flight)
  logic [CW-1:0] unfilled;     // allocated slots still waiting for data
  logic [CW-1:0] discard_cnt;  // stale responses still to be dropped
  logic [31:0]   fetch_pc;
  logic          running;      // holds off requests until the first edge after reset

  logic [PW-1:0]    head_n, tail_n, fill_n;
  logic [CW-1:0]    count_n, unfilled_n, discard_n;
  logic [31:0]      fetch_pc_n;
  logic [DEPTH-1:0] filled_n;

  logic [CW:0] allocated;
  logic        req_fire;
  logic        pop_fire;
  logic        rsp_fill;
  logic        rsp_drop;

  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  // Stale requests keep their slot budget until their responses are dropped,
  // so old and new traffic together never exceed DEPTH.
  assign allocated      = {1'b0, count} + {1'b0, discard_cnt};
  assign imem_req_valid = running && (allocated < DEPTH_A);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign instr_valid = slot_filled[head];
  assign instr       = slot_data[head];
  assign instr_pc    = slot_pc[head];
  assign pop_fire    = instr_valid && instr_ready;

  assign rsp_fill = imem_rsp_valid && (discard_cnt == '0);
  assign rsp_drop = imem_rsp_valid && (discard_cnt != '0);

  // Next-state for control state
  always_comb begin
    fetch_pc_n = fetch_pc;
    head_n     = head;
    tail_n     = tail;
    fill_n     = fill;
    count_n    = count;
    unfilled_n = unfilled;
    discard_n  = discard_cnt;
    filled_n   = slot_filled;

    if (redirect_valid) begin
      fetch_pc_n = {redirect_pc[31:2], 2'b00};
      head_n     = '0;
      tail_n     = '0;
      fill_n     = '0;
      count_n    = '0;
      unfilled_n = '0;
      filled_n   = '0;
      // Every outstanding request becomes stale, including one accepted this
      // cycle. A response arriving now retires one outstanding request (either
      // an already-stale one or an unfilled slot), so it comes off the total.
      discard_n  = discard_cnt + unfilled + CW'(req_fire) - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_n     = fetch_pc + 32'd4;
        tail_n         = tail + PW'(1);
        filled_n[tail] = 1'b0;
      end
      if (rsp_fill) begin
        filled_n[fill] = 1'b1;
        fill_n         = fill + PW'(1);
      end
      if (rsp_drop) begin
        discard_n = discard_cnt - CW'(1);
      end
      if (pop_fire) begin
        filled_n[head] = 1'b0;
        head_n         = head + PW'(1);
      end
      count_n    = count + CW'(req_fire) - CW'(pop_fire);
      unfilled_n = unfilled + CW'(req_fire) - CW'(rsp_fill);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      fill        <= '0;
      count       <= '0;
      unfilled    <= '0;
      discard_cnt <= '0;
      slot_filled <= '0;
      running     <= 1'b0;
    end else begin
      fetch_pc    <= fetch_pc_n;
      head        <= head_n;
      tail        <= tail_n;
      fill        <= fill_n;
      count       <= count_n;
      unfilled    <= unfilled_n;
      discard_cnt <= discard_n;
      slot_filled <= filled_n;
      running     <= 1'b1;
    end
  end

  // Payload storage; written only outside redirect cycles since a redirect
  // throws away everything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc[i]   <= '0;
        slot_data[i] <= '0;
      end
    end else if (!redirect_valid) begin
      if (req_fire) begin
        slot_pc[tail] <= fetch_pc;
      end
      if (rsp_fill) begin
        slot_data[fill] <= imem_rsp_data;
      end
    end
  end

  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> ((unfilled + discard_cnt) != '0));

  a_discard_bound: assert property (@(posedge clk) disable iff (!rst)
    ({1'b0, discard_cnt} <= DEPTH_A));

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue

module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] req_log[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_ins[$];

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic clear_logs();
    mq_addr.delete();
    mq_due.delete();
    req_log.delete();
    pop_pc.delete();
    pop_ins.delete();
  endtask

  task automatic idle_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
  endtask

  // Leaves the bench at posedge+1 of the first cycle in which requests may issue.
  task automatic do_reset(input int latency);
    rst = 1'b0;
    idle_inputs();
    clear_logs();
    lat = latency;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
  endtask

  // One clock cycle: drive inputs, play the memory, log handshakes, advance.
  task automatic cycle(input bit rr, input bit ir, input bit rd, input logic [31:0] rpc);
    imem_req_ready = rr;
    instr_ready    = ir;
    redirect_valid = rd;
    redirect_pc    = rpc;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(mq_addr[0]);
      mq_addr.delete(0);
      mq_due.delete(0);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    if (imem_req_valid && rr) begin
      req_log.push_back(imem_req_addr);
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(cyc + lat);
    end
    if (instr_valid && ir) begin
      pop_pc.push_back(instr_pc);
      pop_ins.push_back(instr);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    clear_logs();
    repeat (2) @(posedge clk);
    #1;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_instr_valid got=%b exp=0", instr_valid); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instr); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL rst_instr_pc got=%h exp=0", instr_pc); end
    total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_req_addr); end
    rst = 1'b1;
    #1;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rel_req_valid_pre_edge got=%b exp=0", imem_req_valid); end
    @(posedge clk);
    #1;
    total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL rel_req_valid_first got=%b exp=1", imem_req_valid); end
    total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL rel_addr_first got=%h exp=0", imem_req_addr); end
  endtask

  task automatic test_stream();
    do_reset(1);
    repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (req_log.size() != 10) begin bad++; $display("FAIL t1_req_count got=%0d exp=10", req_log.size()); end
    for (int i = 0; i < 3 && i < req_log.size(); i++) begin
      total++; if (req_log[i] !== 32'(4 * i)) begin bad++; $display("FAIL t1_req_addr[%0d] got=%h exp=%h", i, req_log[i], 32'(4 * i)); end
    end
    total++; if (pop_pc.size() != 8) begin bad++; $display("FAIL t1_pop_count got=%0d exp=8", pop_pc.size()); end
    for (int i = 0; i < pop_pc.size(); i++) begin
      total++; if (pop_pc[i] !== 32'(4 * i)) begin bad++; $display("FAIL t1_pop_pc[%0d] got=%h exp=%h", i, pop_pc[i], 32'(4 * i)); end
      total++; if (pop_ins[i] !== memf(32'(4 * i))) begin bad++; $display("FAIL t1_pop_instr[%0d] got=%h exp=%h", i, pop_ins[i], memf(32'(4 * i))); end
    end
  endtask

  task automatic test_full();
    do_reset(1);
    repeat (8) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    total++; if (req_log.size() != 4) begin bad++; $display("FAIL t2_req_count got=%0d exp=4", req_log.size()); end
    for (int i = 0; i < req_log.size(); i++) begin
      total++; if (req_log[i] !== 32'(4 * i)) begin bad++; $display("FAIL t2_req_addr[%0d] got=%h exp=%h", i, req_log[i], 32'(4 * i)); end
    end
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL t2_full_req_valid got=%b exp=0", imem_req_valid); end
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL t2_head_valid got=%b exp=1", instr_valid); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL t2_head_pc got=%h exp=0", instr_pc); end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (pop_pc.size() != 1 || pop_pc[0] !== 32'h0) begin bad++; $display("FAIL t2_pop got_n=%0d exp_n=1 exp_pc=0", pop_pc.size()); end
    total++; if (req_log.size() != 4) begin bad++; $display("FAIL t2_no_req_in_pop_cycle got=%0d exp=4", req_log.size()); end
    total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL t2_req_after_pop got=%b exp=1", imem_req_valid); end
    total++; if (imem_req_addr !== 32'h10) begin bad++; $display("FAIL t2_addr_after_pop got=%h exp=10", imem_req_addr); end
    total++; if (instr_pc !== 32'h4) begin bad++; $display("FAIL t2_new_head_pc got=%h exp=4", instr_pc); end
  endtask

  task automatic test_redirect_inflight();
    do_reset(3);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 32'h100);
    total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL t3_req_after_redirect got=%b exp=1", imem_req_valid); end
    total++; if (imem_req_addr !== 32'h100) begin bad++; $display("FAIL t3_addr_after_redirect got=%h exp=100", imem_req_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL t3_valid_after_redirect got=%b exp=0", instr_valid); end
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (pop_pc.size() < 2) begin bad++; $display("FAIL t3_pop_count got=%0d exp>=2", pop_pc.size()); end
    total++; if (pop_pc[0] !== 32'h100) begin bad++; $display("FAIL t3_first_pc got=%h exp=100", pop_pc[0]); end
    total++; if (pop_ins[0] !== memf(32'h100)) begin bad++; $display("FAIL t3_first_instr got=%h exp=%h", pop_ins[0], memf(32'h100)); end
    total++; if (pop_pc[1] !== 32'h104) begin bad++; $display("FAIL t3_second_pc got=%h exp=104", pop_pc[1]); end
    total++; if (req_log[2] !== 32'h100) begin bad++; $display("FAIL t3_req_after_redirect got=%h exp=100", req_log[2]); end
  endtask

  task automatic test_redirect_collide();
    do_reset(1);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'h203);
    total++; if (req_log.size() != 2) begin bad++; $display("FAIL t4_req_in_redirect got=%0d exp=2", req_log.size()); end
    total++; if (imem_req_addr !== 32'h200) begin bad++; $display("FAIL t4_addr got=%h exp=200", imem_req_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL t4_valid_after_redirect got=%b exp=0", instr_valid); end
    repeat (5) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (pop_pc.size() < 2) begin bad++; $display("FAIL t4_pop_count got=%0d exp>=2", pop_pc.size()); end
    total++; if (pop_pc[0] !== 32'h200) begin bad++; $display("FAIL t4_first_pc got=%h exp=200", pop_pc[0]); end
    total++; if (pop_ins[0] !== memf(32'h200)) begin bad++; $display("FAIL t4_first_instr got=%h exp=%h", pop_ins[0], memf(32'h200)); end
    total++; if (pop_pc[1] !== 32'h204) begin bad++; $display("FAIL t4_second_pc got=%h exp=204", pop_pc[1]); end
    total++; if (req_log[2] !== 32'h200) begin bad++; $display("FAIL t4_refetch_addr got=%h exp=200", req_log[2]); end
  endtask

  task automatic test_backpressure();
    do_reset(1);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
        bad++; $display("FAIL t5_stall[%0d] got_valid=%b got_addr=%h exp_valid=1 exp_addr=8", i, imem_req_valid, imem_req_addr);
      end
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
    end
    total++; if (req_log.size() != 2) begin bad++; $display("FAIL t5_no_alloc got=%0d exp=2", req_log.size()); end
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    total++; if (req_log.size() != 4) begin bad++; $display("FAIL t5_req_count got=%0d exp=4", req_log.size()); end
    total++; if (req_log[2] !== 32'h8) begin bad++; $display("FAIL t5_resume_addr got=%h exp=8", req_log[2]); end
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL t5_full got=%b exp=0", imem_req_valid); end
  endtask

  task automatic test_midreset();
    do_reset(1);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin bad++; $display("FAIL t6_pre got_valid=%b got_pc=%h exp_valid=1 exp_pc=0", instr_valid, instr_pc); end
    #2;
    rst = 1'b0;
    #1;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL t6_req_valid got=%b exp=0", imem_req_valid); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL t6_instr_valid got=%b exp=0", instr_valid); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL t6_instr got=%h exp=0", instr); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL t6_instr_pc got=%h exp=0", instr_pc); end
    total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL t6_addr got=%h exp=0", imem_req_addr); end
    idle_inputs();
    clear_logs();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL t6_first_req got_valid=%b got_addr=%h exp_valid=1 exp_addr=0", imem_req_valid, imem_req_addr); end
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (req_log.size() < 1 || req_log[0] !== 32'h0) begin bad++; $display("FAIL t6_req0 got_n=%0d exp_addr=0", req_log.size()); end
    total++; if (pop_pc.size() < 1 || pop_pc[0] !== 32'h0) begin bad++; $display("FAIL t6_pop0 got_n=%0d exp_pc=0", pop_pc.size()); end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_stream();
    test_full();
    test_redirect_inflight();
    test_redirect_collide();
    test_backpressure();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
